mem_ctrl_resp: RTL and testbench

//  Responder end of the arbiter-to-memory-controller link. Accepts READ/WRITE line commands

---
 rtl/mem_if_pkg.sv | 44 ++++
 rtl/cl_word_serdes.sv | 54 +++++
 rtl/mem_ctrl_resp.sv | 147 ++++++++++++++
 tb/tb_mem_ctrl_resp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// ---------------------------------------------------------------------------
// mem_if_pkg
// Shared definitions for the arbiter-to-memory-controller link, used by both
// mem_req_arb (requester) and mem_ctrl_resp (responder).
//   - op_t          : command encoding carried on the op lines
//   - resp_state_t  : responder FSM states
//   - bus / line / address geometry and the derived beat counts
//   - line_align()  : clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package mem_if_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int CL_SIZE_WIDTH    = 512;
    localparam int ADDR_BITCOUNT    = 64;
    localparam int WORDS_PER_CL     = CL_SIZE_WIDTH / WORD_SIZE;
    localparam int ADDR_BEATS       = ADDR_BITCOUNT / WORD_SIZE;
    localparam int BEAT_CNT_W       = $clog2(WORDS_PER_CL);
    localparam int LINE_OFFSET_BITS = $clog2(CL_SIZE_WIDTH / 8);

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_HI,
        ST_WR_DATA,
        ST_HOST_WAIT,
        ST_RD_STREAM,
        ST_DONE
    } resp_state_t;

    // Host memory works on whole lines, so the byte offset inside the line
    // is always presented as zero.
    function automatic logic [ADDR_BITCOUNT-1:0] line_align(
        input logic [ADDR_BITCOUNT-1:0] addr
    );
        return {addr[ADDR_BITCOUNT-1:LINE_OFFSET_BITS], {LINE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cl_word_serdes.sv
// ---------------------------------------------------------------------------
// cl_word_serdes
// Cache-line register with word-wide serial access in both directions.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   load_beat      : shift beat_in into the top of the line (beat 0 first)
//   next_beat      : shift the line down one word to present the next beat
//   parallel_load  : load the whole line from line_in, restart beat count
//   beat_in        : incoming write beat
//   line_in        : incoming read line
//   line           : current line contents
//   beat_out       : lowest word of the line (current read beat)
//   last_beat      : the beat being handled this cycle is the final one
// ---------------------------------------------------------------------------
module cl_word_serdes
    import mem_if_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_beat,
    input  logic                     next_beat,
    input  logic                     parallel_load,
    input  logic [WORD_SIZE-1:0]     beat_in,
    input  logic [CL_SIZE_WIDTH-1:0] line_in,
    output logic [CL_SIZE_WIDTH-1:0] line,
    output logic [WORD_SIZE-1:0]     beat_out,
    output logic                     last_beat
);

    logic [BEAT_CNT_W-1:0] beat_cnt;

    // Both directions shift toward bit 0: on the way in, after all beats
    // word 0 has reached the bottom; on the way out, word 0 is presented
    // first. The counter wraps naturally to 0 after the final beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            line     <= '0;
            beat_cnt <= '0;
        end else if (parallel_load) begin
            line     <= line_in;
            beat_cnt <= '0;
        end else if (load_beat) begin
            line     <= {beat_in, line[CL_SIZE_WIDTH-1:WORD_SIZE]};
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
        end else if (next_beat) begin
            line     <= {{WORD_SIZE{1'b0}}, line[CL_SIZE_WIDTH-1:WORD_SIZE]};
            beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
        end
    end

    assign beat_out  = line[WORD_SIZE-1:0];
    assign last_beat = (beat_cnt == BEAT_CNT_W'(WORDS_PER_CL - 1));

endmodule

// File: rtl/mem_ctrl_resp.sv
// ---------------------------------------------------------------------------
// mem_ctrl_resp
// Responder end of the arbiter-to-memory-controller link. Takes READ/WRITE
// line commands over the 32-bit common data bus, performs one 512-bit
// access on the host-memory port per command and streams read lines back.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   op                         : command (NOP/READ/WRITE/reserved)
//   common_data_bus_write_out  : address and write beats from the arbiter
//   common_data_bus_read_in    : read beats to the arbiter (0 when idle)
//   ready                      : idle, a new op may be sampled
//   tx_done                    : one-cycle completion pulse
//   rd_valid                   : read beat valid on common_data_bus_read_in
//   host_req / host_we         : line access request / write enable
//   host_addr / host_wdata     : line address (offset zeroed) / write line
//   host_ack / host_rdata      : access complete / read line
// ---------------------------------------------------------------------------
module mem_ctrl_resp
    import mem_if_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               op,
    input  logic [WORD_SIZE-1:0]     common_data_bus_write_out,
    output logic [WORD_SIZE-1:0]     common_data_bus_read_in,
    output logic                     ready,
    output logic                     tx_done,
    output logic                     rd_valid,
    output logic                     host_req,
    output logic                     host_we,
    output logic [ADDR_BITCOUNT-1:0] host_addr,
    output logic [CL_SIZE_WIDTH-1:0] host_wdata,
    input  logic                     host_ack,
    input  logic [CL_SIZE_WIDTH-1:0] host_rdata
);

    localparam int ADDR_HI_LSB = ADDR_BITCOUNT / ADDR_BEATS;

    resp_state_t              state;
    resp_state_t              next_state;
    op_t                      op_q;
    logic [ADDR_BITCOUNT-1:0] addr_q;

    logic                     capture_lo;
    logic                     capture_hi;
    logic                     load_beat;
    logic                     next_beat;
    logic                     parallel_load;
    logic                     last_beat;
    logic [WORD_SIZE-1:0]     beat_out;

    cl_word_serdes u_serdes (
        .clk           (clk),
        .rst           (rst),
        .load_beat     (load_beat),
        .next_beat     (next_beat),
        .parallel_load (parallel_load),
        .beat_in       (common_data_bus_write_out),
        .line_in       (host_rdata),
        .line          (host_wdata),
        .beat_out      (beat_out),
        .last_beat     (last_beat)
    );

    // State, command and address registers. The command is only captured
    // in IDLE, so op changes during a transfer have no effect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_q   <= OP_NOP;
            addr_q <= '0;
        end else begin
            state <= next_state;
            if (capture_lo) begin
                op_q                     <= op_t'(op);
                addr_q[ADDR_HI_LSB-1:0] <= common_data_bus_write_out;
            end
            if (capture_hi) begin
                addr_q[ADDR_BITCOUNT-1:ADDR_HI_LSB] <= common_data_bus_write_out;
            end
        end
    end

    // Next-state and Moore outputs. Handshake outputs depend only on the
    // state, so a reset returns them to idle values on the same edge.
    always_comb begin
        next_state    = state;
        ready         = 1'b0;
        tx_done       = 1'b0;
        rd_valid      = 1'b0;
        host_req      = 1'b0;
        capture_lo    = 1'b0;
        capture_hi    = 1'b0;
        load_beat     = 1'b0;
        next_beat     = 1'b0;
        parallel_load = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (op == OP_READ || op == OP_WRITE) begin
                    capture_lo = 1'b1;
                    next_state = ST_ADDR_HI;
                end
            end
            ST_ADDR_HI: begin
                capture_hi = 1'b1;
                next_state = (op_q == OP_WRITE) ? ST_WR_DATA : ST_HOST_WAIT;
            end
            ST_WR_DATA: begin
                load_beat = 1'b1;
                if (last_beat) begin
                    next_state = ST_HOST_WAIT;
                end
            end
            ST_HOST_WAIT: begin
                host_req = 1'b1;
                if (host_ack) begin
                    if (op_q == OP_READ) begin
                        parallel_load = 1'b1;
                        next_state    = ST_RD_STREAM;
                    end else begin
                        next_state = ST_DONE;
                    end
                end
            end
            ST_RD_STREAM: begin
                rd_valid  = 1'b1;
                next_beat = 1'b1;
                if (last_beat) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                tx_done    = 1'b1;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign host_we                 = host_req && (op_q == OP_WRITE);
    assign host_addr               = line_align(addr_q);
    assign common_data_bus_read_in = rd_valid ? beat_out : '0;

endmodule

// File: tb/tb_mem_ctrl_resp.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl_resp
// Self-checking bench for mem_ctrl_resp. A table of directed commands and a
// batch of random commands are driven beat by beat; expected host-side
// values and read beats come from the command itself (aligned address,
// line words) rather than from the design.
// ---------------------------------------------------------------------------
module tb_mem_ctrl_resp;

    logic         clk;
    logic         rst;
    logic [1:0]   op;
    logic [31:0]  bus_w;
    logic [31:0]  bus_r;
    logic         ready;
    logic         tx_done;
    logic         rd_valid;
    logic         host_req;
    logic         host_we;
    logic [63:0]  host_addr;
    logic [511:0] host_wdata;
    logic         host_ack;
    logic [511:0] host_rdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic [63:0] addr;
        int          ack_delay;
        logic [31:0] base;
        logic [63:0] exp_addr;
        bit          exp_we;
        bit          spurious;
    } vec_t;

    mem_ctrl_resp dut (
        .clk                       (clk),
        .rst                       (rst),
        .op                        (op),
        .common_data_bus_write_out (bus_w),
        .common_data_bus_read_in   (bus_r),
        .ready                     (ready),
        .tx_done                   (tx_done),
        .rd_valid                  (rd_valid),
        .host_req                  (host_req),
        .host_we                   (host_we),
        .host_addr                 (host_addr),
        .host_wdata                (host_wdata),
        .host_ack                  (host_ack),
        .host_rdata                (host_rdata)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself ever stalls.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance one cycle; everything is sampled and driven 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [511:0] act,
                                input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [511:0] ramp_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base + 32'(k);
        return l;
    endfunction

    // Drives one complete command and checks every phase of it. A read can
    // be cut short by a reset at beat abort_beat (negative = no abort).
    task automatic apply_stimulus(input logic [1:0] cmd, input logic [63:0] addr,
                                  input int ack_delay, input logic [511:0] line,
                                  input logic [63:0] exp_addr, input bit exp_we,
                                  input bit spurious, input int abort_beat);
        check_output("ready_at_issue", ready, 1);
        op    = cmd;
        bus_w = addr[31:0];
        tick();
        check_output("ready_low_after_issue", ready, 0);
        check_output("no_req_in_addr_hi", host_req, 0);
        op    = 2'($urandom_range(0, 3));
        bus_w = addr[63:32];
        tick();
        if (cmd == 2'b10) begin
            for (int k = 0; k < 16; k++) begin
                bus_w    = line[32*k +: 32];
                host_ack = spurious && (k == 3);
                op       = 2'($urandom_range(0, 3));
                check_output("no_req_in_wr_data", host_req, 0);
                tick();
            end
            host_ack = 1'b0;
        end
        for (int d = 0; d < ack_delay; d++) begin
            op         = 2'($urandom_range(0, 3));
            bus_w      = $urandom;
            host_rdata = rand_line();
            check_output("host_req_held", host_req, 1);
            check_output("host_addr_stable", host_addr, exp_addr);
            check_output("host_we_wait", host_we, exp_we);
            check_output("tx_done_quiet_wait", tx_done, 0);
            tick();
        end
        check_output("host_req_at_ack", host_req, 1);
        check_output("host_addr_at_ack", host_addr, exp_addr);
        check_output("host_we_at_ack", host_we, exp_we);
        if (cmd == 2'b10) check_output("host_wdata", host_wdata, line);
        host_ack   = 1'b1;
        host_rdata = (cmd == 2'b01) ? line : rand_line();
        tick();
        host_ack   = 1'b0;
        host_rdata = rand_line();
        check_output("host_req_drop", host_req, 0);
        if (cmd == 2'b01) begin
            for (int k = 0; k < 16; k++) begin
                op = 2'($urandom_range(0, 3));
                check_output("rd_valid_beat", rd_valid, 1);
                check_output("rd_beat_data", bus_r, line[32*k +: 32]);
                check_output("tx_done_quiet_rd", tx_done, 0);
                if (k == abort_beat) begin
                    rst = 1'b1;
                    op  = 2'b00;
                    tick();
                    rst = 1'b0;
                    check_output("abort_rd_valid", rd_valid, 0);
                    check_output("abort_ready", ready, 1);
                    check_output("abort_tx_done", tx_done, 0);
                    check_output("abort_host_req", host_req, 0);
                    check_output("abort_bus_zero", bus_r, 0);
                    tick();
                    check_output("abort_no_late_done", tx_done, 0);
                    check_output("abort_still_ready", ready, 1);
                    return;
                end
                tick();
            end
        end
        op = 2'b00;
        check_output("tx_done_pulse", tx_done, 1);
        check_output("rd_valid_low_done", rd_valid, 0);
        check_output("bus_zero_done", bus_r, 0);
        check_output("ready_low_done", ready, 0);
        tick();
        check_output("tx_done_single", tx_done, 0);
    endtask

    initial begin
        vec_t         vecs[5];
        logic [63:0]  a;
        logic [1:0]   c;
        logic [511:0] l;

        vecs[0] = '{2'b10, 64'h0000_0001_2345_67C0, 3,   32'h0000_0100,
                    64'h0000_0001_2345_67C0, 1'b1, 1'b1};
        vecs[1] = '{2'b01, 64'h0000_0000_0000_00BF, 0,   32'h0000_A000,
                    64'h0000_0000_0000_0080, 1'b0, 1'b0};
        vecs[2] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 200, 32'hDEAD_0000,
                    64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 64'h8000_0000_0000_003F, 0,   32'h5555_0000,
                    64'h8000_0000_0000_0000, 1'b1, 1'b1};
        vecs[4] = '{2'b01, 64'h0000_0000_0000_1234, 1,   32'h0000_0000,
                    64'h0000_0000_0000_1200, 1'b0, 1'b0};

        rst        = 1'b1;
        op         = 2'b00;
        bus_w      = '0;
        host_ack   = 1'b0;
        host_rdata = '0;
        tick();
        tick();
        check_output("reset_ready", ready, 1);
        check_output("reset_tx_done", tx_done, 0);
        check_output("reset_rd_valid", rd_valid, 0);
        check_output("reset_host_req", host_req, 0);
        check_output("reset_host_we", host_we, 0);
        check_output("reset_host_addr", host_addr, 0);
        check_output("reset_host_wdata", host_wdata, 0);
        check_output("reset_bus", bus_r, 0);
        rst = 1'b0;
        tick();

        $display("[TB] idle with NOP/reserved ops and spurious ack");
        for (int i = 0; i < 10; i++) begin
            op       = (i % 2 == 1) ? 2'b11 : 2'b00;
            bus_w    = $urandom;
            host_ack = (i == 4);
            tick();
            check_output("idle_ready", ready, 1);
            check_output("idle_host_req", host_req, 0);
            check_output("idle_tx_done", tx_done, 0);
        end
        host_ack = 1'b0;
        op       = 2'b00;

        $display("[TB] directed command table, back to back");
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].cmd, vecs[i].addr, vecs[i].ack_delay,
                           ramp_line(vecs[i].base), vecs[i].exp_addr,
                           vecs[i].exp_we, vecs[i].spurious, -1);
        end

        $display("[TB] reset during read stream");
        apply_stimulus(2'b01, 64'h0000_0000_0000_4000, 2, ramp_line(32'hB000),
                       64'h0000_0000_0000_4000, 1'b0, 1'b0, 5);

        $display("[TB] randomized commands");
        for (int i = 0; i < 20; i++) begin
            c = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            a = {$urandom, $urandom};
            l = rand_line();
            apply_stimulus(c, a, int'($urandom_range(0, 5)), l,
                           a & ~64'h3F, c == 2'b10, 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
